// File: rtl/obi_pkg.sv
// Shared OBI bus definitions: widths and request/response payloads.
package obi_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;
  localparam int unsigned OBI_BW = OBI_DW / 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [OBI_BW-1:0] be;
    logic [OBI_AW-1:0] addr;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/obi_master_if_sync_fifo.sv
// Synchronous FIFO with registered storage; any DEPTH >= 1 via explicit pointer wrap.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A pop frees a slot in the same cycle, so push-on-full is legal alongside it.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/obi_master_if.sv
// OBI initiator: client valid/ready commands to OBI req/gnt/rvalid, in-order,
// credit-limited so the response buffer can always absorb un-stallable rvalid.
module obi_master_if
  import obi_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [OBI_BW-1:0] cmd_be_i,
  input  logic [OBI_AW-1:0] cmd_addr_i,
  input  logic [OBI_DW-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [OBI_DW-1:0] rsp_rdata_o,
  output logic              rsp_we_o,
  output logic              req_o,
  output logic              we_o,
  output logic [OBI_BW-1:0] be_o,
  output logic [OBI_AW-1:0] addr_o,
  output logic [OBI_DW-1:0] data_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [OBI_DW-1:0] data_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  obi_req_t      req_q, req_d;
  obi_rsp_t      bus_rsp;
  logic [CW-1:0] credit_q, credit_d;
  logic          err_q;
  logic          cmd_hs, rsp_hs, gnt_fire, rvalid_ok;
  logic          if_we, if_empty, if_full, rsp_empty, rsp_full;
  logic [CW-1:0] if_count, rsp_count;
  logic [OBI_DW:0] rsp_word;
  logic          unused_fifo_status;

  assign bus_rsp = '{gnt: gnt_i, rvalid: rvalid_i, rdata: data_i};

  assign rsp_hs      = rsp_valid_o && rsp_ready_i;
  assign cmd_ready_o = (!req_q.req || bus_rsp.gnt) &&
                       ((credit_q < CW'(MAX_OUTSTANDING)) || rsp_hs);
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;
  assign gnt_fire    = req_q.req && bus_rsp.gnt;
  // An rvalid with nothing in flight is dropped and flagged.
  assign rvalid_ok   = bus_rsp.rvalid && !if_empty;

  // Request stage: load on accept, retire on grant.
  always_comb begin
    req_d = req_q;
    if (cmd_hs) begin
      req_d = '{req: 1'b1, we: cmd_we_i, be: cmd_be_i, addr: cmd_addr_i, wdata: cmd_wdata_i};
    end else if (gnt_fire) begin
      req_d.req = 1'b0;
    end
  end

  // Credits cover accepted-but-unconsumed transactions.
  always_comb begin
    credit_d = credit_q;
    if (cmd_hs && !rsp_hs) begin
      credit_d = credit_q + CW'(1);
    end else if (!cmd_hs && rsp_hs) begin
      credit_d = credit_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q    <= '0;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      req_q    <= req_d;
      credit_q <= credit_d;
      if (bus_rsp.rvalid && if_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt_fire),
    .wdata_i (req_q.we),
    .pop_i   (rvalid_ok),
    .rdata_o (if_we),
    .full_o  (if_full),
    .empty_o (if_empty),
    .count_o (if_count)
  );

  sync_fifo #(
    .WIDTH (OBI_DW + 1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rvalid_ok),
    .wdata_i ({if_we, bus_rsp.rdata}),
    .pop_i   (rsp_hs),
    .rdata_o (rsp_word),
    .full_o  (rsp_full),
    .empty_o (rsp_empty),
    .count_o (rsp_count)
  );

  assign unused_fifo_status = ^{if_full, if_count, rsp_full, rsp_count};

  assign req_o       = req_q.req;
  assign we_o        = req_q.we;
  assign be_o        = req_q.be;
  assign addr_o      = req_q.addr;
  assign data_o      = req_q.wdata;
  assign rsp_valid_o = !rsp_empty;
  assign rsp_we_o    = rsp_word[OBI_DW];
  assign rsp_rdata_o = rsp_word[OBI_DW-1:0];
  assign busy_o      = (credit_q != '0);
  assign err_o       = err_q;

endmodule

// File: tb/tb_obi_master_if.sv
// Bench for obi_master_if: queue-based transaction model checked every cycle,
// a responding OBI slave, and directed scenarios with literal expectations.
module tb_obi_master_if;

  localparam int unsigned MAXO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [3:0]  cmd_be_i = '0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_we_o;
  logic [31:0] rsp_rdata_o;
  logic        req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, data_o;
  logic        gnt_i = 1'b0, rvalid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        busy_o, err_o;

  obi_master_if #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_be_i(cmd_be_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_we_o(rsp_we_o), .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o),
    .data_o(data_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i), .data_i(data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0, n_err = 0, cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic logic [31:0] sd(input logic [31:0] a);
    return a ^ 32'h9EAD_BEEB;
  endfunction

  // Slave: grant after gnt_delay request cycles, answer the next cycle.
  int          gnt_delay = 0, wait_cnt = 0;
  logic        fire = 1'b0, spur = 1'b0;
  logic [31:0] fire_addr = '0;
  always @(negedge clk_i) begin
    fire      = rst_ni && req_o && gnt_i;
    fire_addr = addr_o;
  end
  always @(posedge clk_i) begin
    #1;
    if (!rst_ni) begin
      gnt_i = 1'b0; rvalid_i = 1'b0; data_i = '0; wait_cnt = 0;
    end else begin
      rvalid_i = fire || spur;
      data_i   = fire ? sd(fire_addr) : (spur ? 32'h1234_5678 : '0);
      if (fire) wait_cnt = 0;
      if (req_o) begin
        gnt_i = (wait_cnt >= gnt_delay);
        if (!gnt_i) wait_cnt++;
      end else begin
        gnt_i = 1'b0;
      end
    end
  end

  // Transaction-level model: pending request, in-flight and response queues.
  logic        m_req = 1'b0, m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_credit = 0;
  logic        m_err = 1'b0;
  logic        mq_if[$];
  logic [32:0] mq_rsp[$];

  function automatic logic m_ready();
    return (!m_req || gnt_i) &&
           ((m_credit < int'(MAXO)) || ((mq_rsp.size() != 0) && rsp_ready_i));
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    logic hs, rhs, g, w;
    if (!rst_ni) begin
      m_req = 1'b0; m_credit = 0; m_err = 1'b0;
      mq_if.delete(); mq_rsp.delete();
    end else begin
      hs  = cmd_valid_i && m_ready();
      rhs = (mq_rsp.size() != 0) && rsp_ready_i;
      g   = m_req && gnt_i;
      if (rhs) void'(mq_rsp.pop_front());
      if (rvalid_i) begin
        if (mq_if.size() == 0) m_err = 1'b1;
        else begin
          w = mq_if.pop_front();
          mq_rsp.push_back({w, data_i});
        end
      end
      if (g) mq_if.push_back(m_we);
      if (hs) begin
        m_req = 1'b1; m_we = cmd_we_i; m_be = cmd_be_i;
        m_addr = cmd_addr_i; m_wdata = cmd_wdata_i;
      end else if (g) begin
        m_req = 1'b0;
      end
      m_credit = m_credit + int'(hs) - int'(rhs);
    end
  end

  always @(negedge clk_i) begin
    chk1("m_req_o", req_o, m_req);
    if (m_req) begin
      chk1("m_we_o", we_o, m_we);
      chk("m_be_o", {28'd0, be_o}, {28'd0, m_be});
      chk("m_addr_o", addr_o, m_addr);
      chk("m_data_o", data_o, m_wdata);
    end
    chk1("m_rsp_valid", rsp_valid_o, mq_rsp.size() != 0);
    if (mq_rsp.size() != 0) begin
      chk("m_rsp_rdata", rsp_rdata_o, mq_rsp[0][31:0]);
      chk1("m_rsp_we", rsp_we_o, mq_rsp[0][32]);
    end
    chk1("m_busy", busy_o, m_credit != 0);
    chk1("m_err", err_o, m_err);
    chk1("m_cmd_ready", cmd_ready_o, m_ready());
  end

  task automatic set_cmd(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] d);
    cmd_we_i = we; cmd_be_i = be; cmd_addr_i = a; cmd_wdata_i = d;
  endtask

  // Present one command; returns in the cycle after acceptance.
  task automatic send(input logic we, input logic [3:0] be, input logic [31:0] a,
                      input logic [31:0] d);
    int n;
    @(posedge clk_i); #2;
    cmd_valid_i = 1'b1;
    set_cmd(we, be, a, d);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!cmd_ready_o && n < 50);
    chk1("send_accept", cmd_ready_o, 1'b1);
    @(posedge clk_i); #2;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!rsp_valid_o && n < 40);
    chk1(name, rsp_valid_o, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk_i); n++; end while ((busy_o || req_o) && n < 60);
    chk1("drain_busy", busy_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx, got, first_c, last_c;
    logic acc;

    repeat (3) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(negedge clk_i);
    chk1("rst_cmd_ready", cmd_ready_o, 1'b1);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);

    // Single zero-wait read: req at N+1, response at N+3.
    send(1'b0, 4'hF, 32'h4000_0004, 32'h0);
    @(negedge clk_i);
    chk1("t1_req_n1", req_o, 1'b1);
    chk("t1_addr", addr_o, 32'h4000_0004);
    @(negedge clk_i);
    chk1("t1_rsp_n2", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    chk1("t1_rsp_n3", rsp_valid_o, 1'b1);
    chk("t1_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    chk1("t1_rsp_we", rsp_we_o, 1'b0);
    drain();

    // Write with grant delayed 3 cycles: bus held stable for 4 request cycles.
    gnt_delay = 3;
    send(1'b1, 4'b0011, 32'h4000_0000, 32'h0000_00A5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk1("t2_req", req_o, 1'b1);
      chk1("t2_we", we_o, 1'b1);
      chk("t2_be", {28'd0, be_o}, 32'h3);
      chk("t2_addr", addr_o, 32'h4000_0000);
      chk("t2_data", data_o, 32'h0000_00A5);
      chk1("t2_cmd_ready", cmd_ready_o, i == 3);
    end
    gnt_delay = 0;
    wait_rsp("t2_rsp_valid");
    chk1("t2_rsp_we", rsp_we_o, 1'b1);
    chk("t2_rdata", rsp_rdata_o, 32'hDEAD_BEEB);
    drain();

    // Response back-pressure: credit limit stops acceptance at MAXO.
    @(posedge clk_i); #2;
    rsp_ready_i = 1'b0;
    cmd_valid_i = 1'b1;
    idx = 0; got = 0;
    set_cmd(1'b0, 4'hF, 32'h4000_0100, 32'h0);
    for (int c = 0; c < 80 && got < 6; c++) begin
      @(negedge clk_i);
      if (c == 12) begin
        chk("t3_accepted", idx, MAXO);
        chk1("t3_cmd_ready", cmd_ready_o, 1'b0);
        chk1("t3_busy", busy_o, 1'b1);
      end
      acc = cmd_valid_i && cmd_ready_o;
      if (rsp_valid_o && rsp_ready_i) begin
        chk("t3_order", rsp_rdata_o, sd(32'h4000_0100 + 32'(got) * 4));
        got++;
      end
      @(posedge clk_i); #2;
      if (c == 12) rsp_ready_i = 1'b1;
      if (acc) begin
        idx++;
        if (idx < 6) set_cmd(1'b0, 4'hF, 32'h4000_0100 + 32'(idx) * 4, 32'h0);
        else cmd_valid_i = 1'b0;
      end
    end
    chk("t3_responses", got, 6);
    drain();

    // Streaming: one acceptance per cycle once the pipeline is running.
    @(posedge clk_i); #2;
    cmd_valid_i = 1'b1;
    idx = 0; first_c = -1; last_c = 0;
    set_cmd(1'b0, 4'hF, 32'h4000_0200, 32'hC000_0000);
    for (int c = 0; c < 60 && idx < 12; c++) begin
      @(negedge clk_i);
      acc = cmd_ready_o;
      if (acc) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
      end
      @(posedge clk_i); #2;
      if (acc) begin
        idx++;
        if (idx < 12) set_cmd(idx[0], 4'hF, 32'h4000_0200 + 32'(idx) * 4, 32'hC000_0000 + 32'(idx));
        else cmd_valid_i = 1'b0;
      end
    end
    chk("t4_accepted", idx, 12);
    chk("t4_span", 32'(last_c - first_c), 32'd11);
    drain();

    // Spurious rvalid: dropped, error becomes sticky.
    @(posedge clk_i); #2;
    spur = 1'b1;
    @(posedge clk_i); #2;
    spur = 1'b0;
    @(negedge clk_i);
    chk1("t5_err_before", err_o, 1'b0);
    @(negedge clk_i);
    chk1("t5_err_set", err_o, 1'b1);
    chk1("t5_no_rsp", rsp_valid_o, 1'b0);
    repeat (3) @(negedge clk_i);
    chk1("t5_err_sticky", err_o, 1'b1);

    // Asynchronous reset with transactions outstanding.
    @(posedge clk_i); #2;
    rsp_ready_i = 1'b0;
    send(1'b0, 4'hF, 32'h4000_0010, 32'h0);
    send(1'b0, 4'hF, 32'h4000_0014, 32'h0);
    #1 rst_ni = 1'b0;
    #1;
    chk1("t6_req", req_o, 1'b0);
    chk1("t6_rsp_valid", rsp_valid_o, 1'b0);
    chk1("t6_busy", busy_o, 1'b0);
    chk1("t6_err", err_o, 1'b0);
    chk("t6_addr", addr_o, 32'h0);
    chk("t6_rdata", rsp_rdata_o, 32'h0);
    chk1("t6_cmd_ready", cmd_ready_o, 1'b1);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    @(posedge clk_i); #2;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk1("t6_post_ready", cmd_ready_o, 1'b1);
    chk1("t6_post_busy", busy_o, 1'b0);
    send(1'b0, 4'hF, 32'h4000_0008, 32'h0);
    wait_rsp("t6_rsp_valid");
    chk("t6_post_rdata", rsp_rdata_o, 32'hDEAD_BEE3);
    chk1("t6_post_we", rsp_we_o, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
